// File: rtl/shift_seq_counter_if.sv
// Control/load inputs and counter outputs for shift_seq_counter.
// The master side drives the controls; the counter sits on the slave side.
interface shift_seq_counter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(2 * N);

    logic          clr;
    logic          mode;
    logic          en;
    logic          dir;
    logic          load;
    logic [N-1:0]  ld_val;
    logic [N-1:0]  q;
    logic [IW-1:0] idx;
    logic          tc;
    logic          err;

    modport master (
        output clr, mode, en, dir, load, ld_val,
        input  q, idx, tc, err
    );

    modport slave (
        input  clr, mode, en, dir, load, ld_val,
        output q, idx, tc, err
    );
endinterface

// File: rtl/shift_seq_counter.sv
// Johnson / ring shift counter with phase index, wrap pulse and load checking.
// Mode is latched only on reset or clear; out-of-sequence states fall back to the seed.
module shift_seq_counter #(
    parameter int unsigned N = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_seq_counter_if.slave bus
);
    localparam int unsigned IW = $clog2(2 * N);

    logic          m_q,   m_d;
    logic [N-1:0]  q_q,   q_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          tc_q,  tc_d;
    logic          err_q, err_d;

    logic          ld_legal;
    logic [IW-1:0] ld_idx;
    logic          q_legal;
    logic [IW-1:0] idx_last;

    function automatic logic [N-1:0] seed_of(input logic m);
        return m ? {1'b1, {(N-1){1'b0}}} : '0;
    endfunction

    // Mask with the top c bits set.
    function automatic logic [N-1:0] hi_mask(input int unsigned c);
        logic [N-1:0] r;
        for (int unsigned i = 0; i < N; i++) r[i] = (i + c >= N);
        return r;
    endfunction

    // Mask with the bottom c bits set.
    function automatic logic [N-1:0] lo_mask(input int unsigned c);
        logic [N-1:0] r;
        for (int unsigned i = 0; i < N; i++) r[i] = (i < c);
        return r;
    endfunction

    function automatic int unsigned ones_of(input logic [N-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < N; i++) c += 32'(v[i]);
        return c;
    endfunction

    // Johnson states are a contiguous run of ones anchored at either end.
    function automatic logic is_legal(input logic [N-1:0] v, input logic m);
        int unsigned c;
        c = ones_of(v);
        if (m) return (c == 1);
        return (v == hi_mask(c)) || (v == lo_mask(c));
    endfunction

    function automatic logic [IW-1:0] map_idx(input logic [N-1:0] v, input logic m);
        int unsigned   c;
        logic [IW-1:0] r;
        c = ones_of(v);
        r = '0;
        if (m) begin
            for (int unsigned i = 0; i < N; i++)
                if (v[i]) r = IW'(N - 1 - i);
        end else begin
            r = (v == hi_mask(c)) ? IW'(c) : IW'(2 * N - c);
        end
        return r;
    endfunction

    assign ld_legal = is_legal(bus.ld_val, m_q);
    assign ld_idx   = map_idx(bus.ld_val, m_q);
    assign q_legal  = is_legal(q_q, m_q);
    assign idx_last = m_q ? IW'(N - 1) : IW'(2 * N - 1);

    // Next state: clr > load > step > hold.
    always_comb begin
        m_d   = m_q;
        q_d   = q_q;
        idx_d = idx_q;
        tc_d  = 1'b0;
        err_d = 1'b0;
        if (bus.clr) begin
            m_d   = bus.mode;
            q_d   = seed_of(bus.mode);
            idx_d = '0;
        end else if (bus.load) begin
            if (ld_legal) begin
                q_d   = bus.ld_val;
                idx_d = ld_idx;
            end else begin
                q_d   = seed_of(m_q);
                idx_d = '0;
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (!q_legal) begin
                q_d   = seed_of(m_q);
                idx_d = '0;
                err_d = 1'b1;
            end else if (!bus.dir) begin
                q_d   = m_q ? {q_q[0], q_q[N-1:1]} : {~q_q[0], q_q[N-1:1]};
                idx_d = (idx_q == idx_last) ? '0 : idx_q + IW'(1);
                tc_d  = (idx_q == idx_last);
            end else begin
                q_d   = m_q ? {q_q[N-2:0], q_q[N-1]} : {q_q[N-2:0], ~q_q[N-1]};
                idx_d = (idx_q == '0) ? idx_last : idx_q - IW'(1);
                tc_d  = (idx_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= bus.mode;
            q_q   <= seed_of(bus.mode);
            idx_q <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            q_q   <= q_d;
            idx_q <= idx_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.idx = idx_q;
    assign bus.tc  = tc_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_shift_seq_counter.sv
// Bench for shift_seq_counter: directed scenarios plus random traffic against
// a reference that tracks the phase index and regenerates patterns from the shift rules.
module tb_shift_seq_counter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shift_seq_counter_if #(.N(4)) b4 ();
    shift_seq_counter_if #(.N(5)) b5 ();

    shift_seq_counter #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    shift_seq_counter #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));

    // Reference state for the N=4 instance.
    logic       mm;
    int         midx;
    logic [7:0] mq;
    logic       mtc, merr;

    function automatic logic [7:0] seed_ref(int n, logic m);
        return m ? (8'd1 << (n - 1)) : 8'd0;
    endfunction

    // Pattern k steps forward from the seed, built from the forward shift rules.
    function automatic logic [7:0] pat(int n, logic m, int k);
        logic [7:0] v;
        logic       b;
        v = seed_ref(n, m);
        for (int s = 0; s < k; s++) begin
            b = m ? v[0] : ~v[0];
            v = v >> 1;
            v[n-1] = b;
        end
        return v;
    endfunction

    function automatic int find_idx(int n, logic m, logic [7:0] v);
        int per;
        per = m ? n : 2 * n;
        for (int k = 0; k < per; k++)
            if (pat(n, m, k) == v) return k;
        return -1;
    endfunction

    task automatic set4(logic c, logic md, logic e, logic d, logic l, logic [3:0] lv);
        b4.clr = c; b4.mode = md; b4.en = e; b4.dir = d; b4.load = l; b4.ld_val = lv;
    endtask

    // One clock edge for the N=4 instance with the reference advanced alongside.
    task automatic tick4();
        int per, k;
        @(posedge clk);
        mtc = 1'b0;
        merr = 1'b0;
        if (rst || b4.clr) begin
            mm = b4.mode; midx = 0; mq = seed_ref(4, b4.mode);
        end else if (b4.load) begin
            k = find_idx(4, mm, {4'b0, b4.ld_val});
            if (k >= 0) begin
                mq = {4'b0, b4.ld_val}; midx = k;
            end else begin
                mq = seed_ref(4, mm); midx = 0; merr = 1'b1;
            end
        end else if (b4.en) begin
            per = mm ? 4 : 8;
            if (!b4.dir) begin
                midx = (midx + 1) % per; mtc = (midx == 0);
            end else begin
                midx = (midx + per - 1) % per; mtc = (midx == per - 1);
            end
            mq = pat(4, mm, midx);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set4(0, 0, 1, 0, 1, 4'b0101);
        tick4();
        total++;
        if (b4.q !== 4'b0000 || b4.idx !== 3'd0 || b4.tc !== 1'b0 || b4.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_m0 q=%b idx=%0d tc=%b err=%b want 0000/0/0/0", b4.q, b4.idx, b4.tc, b4.err);
        end
        b4.mode = 1'b1;
        tick4();
        total++;
        if (b4.q !== 4'b1000 || b4.idx !== 3'd0 || b4.tc !== 1'b0 || b4.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_m1 q=%b idx=%0d tc=%b err=%b want 1000/0/0/0", b4.q, b4.idx, b4.tc, b4.err);
        end
        rst = 1'b0;
    endtask

    task automatic test_johnson_fwd();
        logic [3:0] jq [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0011, 4'b0001, 4'b0000};
        rst = 1'b1;
        set4(0, 0, 0, 0, 0, 4'b0);
        tick4();
        rst = 1'b0;
        b4.en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick4();
            total++;
            if (b4.q !== jq[i] || b4.idx !== 3'(i % 8) || b4.tc !== (i == 8)) begin
                bad++;
                $display("FAIL johnson_fwd step=%0d q=%b idx=%0d tc=%b want %b/%0d/%b",
                         i, b4.q, b4.idx, b4.tc, jq[i], i % 8, (i == 8));
            end
        end
    endtask

    task automatic test_ring_rev();
        rst = 1'b1;
        set4(0, 1, 0, 0, 0, 4'b0);
        tick4();
        rst = 1'b0;
        b4.en = 1'b1;
        b4.dir = 1'b1;
        tick4();
        total++;
        if (b4.q !== 4'b0001 || b4.idx !== 3'd3 || b4.tc !== 1'b1) begin
            bad++;
            $display("FAIL ring_rev1 q=%b idx=%0d tc=%b want 0001/3/1", b4.q, b4.idx, b4.tc);
        end
        tick4();
        total++;
        if (b4.q !== 4'b0010 || b4.idx !== 3'd2 || b4.tc !== 1'b0) begin
            bad++;
            $display("FAIL ring_rev2 q=%b idx=%0d tc=%b want 0010/2/0", b4.q, b4.idx, b4.tc);
        end
    endtask

    task automatic test_load_hold_clr();
        rst = 1'b1;
        set4(0, 0, 0, 0, 0, 4'b0);
        tick4();
        rst = 1'b0;
        set4(0, 0, 0, 0, 1, 4'b0011);
        tick4();
        total++;
        if (b4.q !== 4'b0011 || b4.idx !== 3'd6 || b4.err !== 1'b0) begin
            bad++;
            $display("FAIL load_legal q=%b idx=%0d err=%b want 0011/6/0", b4.q, b4.idx, b4.err);
        end
        b4.ld_val = 4'b0101;
        tick4();
        total++;
        if (b4.q !== 4'b0000 || b4.idx !== 3'd0 || b4.err !== 1'b1) begin
            bad++;
            $display("FAIL load_illegal q=%b idx=%0d err=%b want 0000/0/1", b4.q, b4.idx, b4.err);
        end
        b4.load = 1'b0;
        tick4();
        total++;
        if (b4.err !== 1'b0) begin
            bad++;
            $display("FAIL err_one_cycle err=%b want 0", b4.err);
        end
        set4(0, 0, 0, 0, 1, 4'b1110);
        tick4();
        b4.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick4();
            total++;
            if (b4.q !== 4'b1110 || b4.idx !== 3'd3 || b4.tc !== 1'b0) begin
                bad++;
                $display("FAIL hold cyc=%0d q=%b idx=%0d tc=%b want 1110/3/0", i, b4.q, b4.idx, b4.tc);
            end
        end
        set4(1, 1, 1, 0, 1, 4'b0001);
        tick4();
        total++;
        if (b4.q !== 4'b1000 || b4.idx !== 3'd0 || b4.err !== 1'b0) begin
            bad++;
            $display("FAIL clr_over_load q=%b idx=%0d err=%b want 1000/0/0", b4.q, b4.idx, b4.err);
        end
        set4(0, 0, 1, 0, 0, 4'b0);
        tick4();
        total++;
        if (b4.q !== 4'b0100 || b4.idx !== 3'd1) begin
            bad++;
            $display("FAIL clr_latched_ring q=%b idx=%0d want 0100/1", b4.q, b4.idx);
        end
    endtask

    task automatic test_random();
        int r, per;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            rst = (r < 2);
            per = mm ? 4 : 8;
            b4.clr    = (r >= 2 && r < 6);
            b4.mode   = 1'($urandom);
            b4.en     = ($urandom_range(0, 3) != 0);
            b4.dir    = 1'($urandom);
            b4.load   = ($urandom_range(0, 7) == 0);
            b4.ld_val = ($urandom_range(0, 1) != 0) ? pat(4, mm, $urandom_range(0, per - 1)) : 4'($urandom);
            tick4();
            total++;
            if (b4.q !== mq[3:0] || b4.idx !== 3'(midx) || b4.tc !== mtc || b4.err !== merr) begin
                bad++;
                $display("FAIL random cyc=%0d q=%b/%b idx=%0d/%0d tc=%b/%b err=%b/%b (got/want)",
                         i, b4.q, mq[3:0], b4.idx, midx, b4.tc, mtc, b4.err, merr);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        set4(0, 1, 0, 0, 0, 4'b0);
        tick4();
        rst = 1'b0;
        b4.en = 1'b1;
        tick4();
        tick4();
        rst = 1'b1;
        set4(1, 1, 1, 1, 1, 4'b0010);
        tick4();
        rst = 1'b0;
        total++;
        if (b4.q !== 4'b1000 || b4.idx !== 3'd0 || b4.tc !== 1'b0 || b4.err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid q=%b idx=%0d tc=%b err=%b want 1000/0/0/0", b4.q, b4.idx, b4.tc, b4.err);
        end
    endtask

    task automatic test_n5_retrace();
        int k;
        logic [7:0] e;
        rst = 1'b1;
        b5.mode = 1'b0; b5.en = 1'b0; b5.dir = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        b5.en = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            b5.dir = (s > 6);
            @(posedge clk); #1;
            k = (s <= 6) ? s : 12 - s;
            e = pat(5, 1'b0, k);
            total++;
            if (b5.q !== e[4:0] || b5.idx !== 4'(k) || b5.tc !== 1'b0) begin
                bad++;
                $display("FAIL n5_retrace step=%0d q=%b idx=%0d tc=%b want %b/%0d/0",
                         s, b5.q, b5.idx, b5.tc, e[4:0], k);
            end
        end
        total++;
        if (b5.q !== 5'b00000 || b5.idx !== 4'd0) begin
            bad++;
            $display("FAIL n5_home q=%b idx=%0d want 00000/0", b5.q, b5.idx);
        end
        b5.en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set4(0, 0, 0, 0, 0, 4'b0);
        b5.clr = 1'b0; b5.mode = 1'b0; b5.en = 1'b0; b5.dir = 1'b0;
        b5.load = 1'b0; b5.ld_val = 5'b0;
        mm = 1'b0; midx = 0; mq = 8'd0; mtc = 1'b0; merr = 1'b0;
        #1;
        test_reset();
        test_johnson_fwd();
        test_ring_rev();
        test_load_hold_clr();
        test_rst_mid();
        test_random();
        test_n5_retrace();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_seq_counter.md
SHIFT_SEQ_COUNTER -- requirements
Module: shift_seq_counter

Interface
REQ-001 Parameter N, default 4, the counter width in bits; the legal range is N >= 2.
REQ-002 Derived constant IW = $clog2(2*N) SHALL set the index width.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clr  input  1  synchronous restart to the seed state; it also re-latches mode.
REQ-006 mode  input  1  sequence select: 0 = Johnson (twisted ring), 1 = ring (one-hot); sampled only at rst or clr.
REQ-007 en  input  1  step enable; while en=0 the state SHALL hold.
REQ-008 dir  input  1  step direction: 0 = forward (shift toward bit 0), 1 = reverse (shift toward bit N-1).
REQ-009 load  input  1  load request for ld_val.
REQ-010 ld_val  input  N  pattern to load.
REQ-011 q  output  N  registered counter state.
REQ-012 idx  output  IW  registered phase index of q within the active sequence.
REQ-013 tc  output  1  registered one-cycle terminal-count (wrap) pulse.
REQ-014 err  output  1  registered one-cycle illegal-load pulse.

Function
REQ-015 An internal mode register m SHALL capture mode on rst or clr and hold it at all other times.
REQ-016 The sequence period P SHALL be 2N when m=0 and N when m=1.
REQ-017 The seed state SHALL be all-zeros at idx=0 when m=0, and 1 at bit N-1 with all other bits 0, at idx=0, when m=1.
REQ-018 Per-edge priority SHALL be rst > clr > load > en-step > hold.
REQ-019 Johnson forward step: q[N-1] <= ~q[0] and q[N-2:0] <= q[N-1:1].
REQ-020 Johnson reverse step: q[0] <= ~q[N-1] and q[N-1:1] <= q[N-2:0].
REQ-021 Ring forward step: q[N-1] <= q[0] and q[N-2:0] <= q[N-1:1].
REQ-022 Ring reverse step: q[0] <= q[N-1] and q[N-1:1] <= q[N-2:0].
REQ-023 Johnson index map: k ones in the top k bits with the rest zero SHALL give idx=k (k=0..N); j ones in the bottom j bits with the rest zero (j=1..N-1) SHALL give idx=2N-j.
REQ-024 Ring index map: a single one at bit b SHALL give idx=N-1-b.
REQ-025 A forward step SHALL set idx <= (idx+1) mod P, and a reverse step SHALL set idx <= (idx-1) mod P, in the same edge as q.
REQ-026 tc SHALL be 1 in the cycle after a step with wrap: forward from idx=P-1 to 0, or reverse from idx=0 to P-1.
REQ-027 tc SHALL be 0 after rst, clr, load, hold and non-wrapping steps.
REQ-028 Load legality SHALL be judged against m: for m=0 ld_val must be one of the 2N Johnson patterns, and for m=1 ld_val must be one-hot.
REQ-029 A legal load SHALL set q <= ld_val and idx <= the mapped index, with err=0 and tc=0.
REQ-030 An illegal load SHALL set q <= seed and idx <= 0, with err=1 for exactly one cycle.
REQ-031 If en=1 and q is not legal for m (for example after an upset), the step SHALL instead set q <= seed and idx <= 0 with err=1.
REQ-032 clr while en=1 or load=1 SHALL win; q SHALL become the seed for the newly latched mode.
REQ-033 dir may change on any cycle; each step SHALL use the dir sampled on that edge.
REQ-034 There SHALL be no combinational path from any input to any output.

Reset
REQ-035 On rst: m <= mode, q <= seed(mode), idx <= 0, tc <= 0, err <= 0.
REQ-036 rst asserted mid-sequence SHALL take effect on the next edge regardless of en, load or clr.

Verification
REQ-037 N=4, rst with mode=0, then en=1, dir=0 for 8 cycles -> q = 0000,1000,1100,1110,1111,0111,0011,0001,0000; idx = 0..7 then 0; tc=1 only after the 7->0 step.
REQ-038 N=4, mode=1, rst, en=1, dir=1 for 2 cycles -> q: 1000 -> 0001 (idx 3, tc=1) -> 0010 (idx 2, tc=0).
REQ-039 N=4, m=0, load ld_val=0011 -> q=0011, idx=6, err=0; then load 0101 -> q=0000, idx=0, err=1 for one cycle.
REQ-040 N=4, m=0 at q=1110 with en=0 for 5 cycles -> q and idx hold and tc=0; then mode=1 with clr=1 and load=1 on the same edge -> q=1000, idx=0, m=1, load ignored.
REQ-041 N=5, m=0, run forward 12 steps, change dir at step 6, run 6 more -> q retraces to the step-0 value, idx returns to 0, and tc stays 0 throughout.
REQ-042 Assert rst together with en=1 and load=1 mid-run -> next cycle q=seed(mode), idx=0, tc=0, err=0.
